// File: rtl/execute_pipe_if.sv
// ID/EX -> EX -> EX/MEM bundle for execute_pipe: decoded operands and control in,
// pipeline handshake and the registered EX/MEM contents out.
interface execute_pipe_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int ADDR_W = 11
);
  logic              in_valid;
  logic              ex_ready;
  logic              mem_stall;
  logic              flush;
  logic              ALUSrc;
  logic              RegDst;
  logic [3:0]        ALUCtrl;
  logic [DATA_W-1:0] registro_1;
  logic [DATA_W-1:0] registro_2;
  logic [DATA_W-1:0] sign_extend;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] jump_dest_addr;
  logic [REG_W-1:0]  reg_dest_r_type;
  logic [REG_W-1:0]  reg_dest_l_type;
  logic              MemToReg_in;
  logic              RegWrite_in;
  logic              MemRead_in;
  logic              MemWrite_in;
  logic              Branch_in;

  logic              out_valid;
  logic [DATA_W-1:0] result_out;
  logic [DATA_W-1:0] registro_2_out;
  logic [ADDR_W-1:0] branch_target_out;
  logic [ADDR_W-1:0] jump_dest_addr_out;
  logic [REG_W-1:0]  reg_dest_out;
  logic              zero_signal_out;
  logic              MemToReg_out;
  logic              RegWrite_out;
  logic              MemRead_out;
  logic              MemWrite_out;
  logic              Branch_out;

  modport master (
    output in_valid, mem_stall, flush, ALUSrc, RegDst, ALUCtrl,
           registro_1, registro_2, sign_extend, pc_plus1, jump_dest_addr,
           reg_dest_r_type, reg_dest_l_type,
           MemToReg_in, RegWrite_in, MemRead_in, MemWrite_in, Branch_in,
    input  ex_ready, out_valid, result_out, registro_2_out, branch_target_out,
           jump_dest_addr_out, reg_dest_out, zero_signal_out,
           MemToReg_out, RegWrite_out, MemRead_out, MemWrite_out, Branch_out
  );

  modport slave (
    input  in_valid, mem_stall, flush, ALUSrc, RegDst, ALUCtrl,
           registro_1, registro_2, sign_extend, pc_plus1, jump_dest_addr,
           reg_dest_r_type, reg_dest_l_type,
           MemToReg_in, RegWrite_in, MemRead_in, MemWrite_in, Branch_in,
    output ex_ready, out_valid, result_out, registro_2_out, branch_target_out,
           jump_dest_addr_out, reg_dest_out, zero_signal_out,
           MemToReg_out, RegWrite_out, MemRead_out, MemWrite_out, Branch_out
  );
endinterface

// File: rtl/execute_pipe.sv
// EX stage with integrated EX/MEM register: single-cycle ALU, iterative shift-add
// multiplier behind a stall handshake, valid/stall/flush control, branch target.
module execute_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int ADDR_W = 11,
  parameter int MUL_EN = 1
) (
  input  logic         clock,
  input  logic         reset,
  execute_pipe_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, MUL_BUSY, MUL_DONE} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] store_data;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] jump_dest;
    logic [REG_W-1:0]  reg_dest;
    logic              mem_to_reg;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
  } ex_op_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [DATA_W-1:0] op2, alu_result, load_result;
  logic [DATA_W-1:0] mcand, mplier, acc;
  ex_op_t            cur_op, held_op, load_op;
  logic              is_mul, accept_mul, load_single, load_mul, load_bubble, ready;

  assign op2    = bus.ALUSrc ? bus.sign_extend : bus.registro_2;
  assign is_mul = (MUL_EN != 0) && (bus.ALUCtrl == 4'd8);

  always_comb begin
    cur_op.store_data    = bus.registro_2;
    cur_op.branch_target = bus.pc_plus1 + bus.sign_extend[ADDR_W-1:0];
    cur_op.jump_dest     = bus.jump_dest_addr;
    cur_op.reg_dest      = bus.RegDst ? bus.reg_dest_r_type : bus.reg_dest_l_type;
    cur_op.mem_to_reg    = bus.MemToReg_in;
    cur_op.reg_write     = bus.RegWrite_in;
    cur_op.mem_read      = bus.MemRead_in;
    cur_op.mem_write     = bus.MemWrite_in;
    cur_op.branch        = bus.Branch_in;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    alu_result = '0;
    case (bus.ALUCtrl)
      4'd0:    alu_result = bus.registro_1 & op2;
      4'd1:    alu_result = bus.registro_1 | op2;
      4'd2:    alu_result = bus.registro_1 + op2;
      4'd6:    alu_result = bus.registro_1 - op2;
      4'd7:    alu_result[0] = $signed(bus.registro_1) < $signed(op2);
      4'd8:    if (MUL_EN == 0) alu_result = bus.registro_1 + op2;
      4'd12:   alu_result = ~(bus.registro_1 | op2);
      default: alu_result = '0;
    endcase
  end

  // Flush outranks everything; a stalled MEM only blocks loads, never iteration.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    accept_mul  = 1'b0;
    load_single = 1'b0;
    load_mul    = 1'b0;
    load_bubble = 1'b0;
    ready       = 1'b0;
    if (bus.flush) begin
      state_n     = IDLE;
      cnt_n       = '0;
      ready       = !bus.mem_stall;
      load_bubble = !bus.mem_stall;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && is_mul) begin
            accept_mul  = 1'b1;
            state_n     = MUL_BUSY;
            cnt_n       = CNT_W'(DATA_W);
            load_bubble = !bus.mem_stall;
          end else begin
            ready       = !bus.mem_stall;
            load_single = !bus.mem_stall && bus.in_valid;
            load_bubble = !bus.mem_stall && !bus.in_valid;
          end
        end
        MUL_BUSY: begin
          cnt_n       = cnt - CNT_W'(1);
          load_bubble = !bus.mem_stall;
          if (cnt == CNT_W'(1)) state_n = MUL_DONE;
        end
        MUL_DONE: begin
          if (!bus.mem_stall) begin
            ready    = 1'b1;
            load_mul = 1'b1;
            state_n  = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.ex_ready = ready && !reset;
  assign load_op      = load_mul ? held_op : cur_op;
  assign load_result  = load_mul ? acc : alu_result;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      held_op <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept_mul) begin
        mcand   <= bus.registro_1;
        mplier  <= op2;
        acc     <= '0;
        held_op <= cur_op;
      end else if (state == MUL_BUSY) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.out_valid          <= 1'b0;
      bus.result_out         <= '0;
      bus.registro_2_out     <= '0;
      bus.branch_target_out  <= '0;
      bus.jump_dest_addr_out <= '0;
      bus.reg_dest_out       <= '0;
      bus.zero_signal_out    <= 1'b0;
      bus.MemToReg_out       <= 1'b0;
      bus.RegWrite_out       <= 1'b0;
      bus.MemRead_out        <= 1'b0;
      bus.MemWrite_out       <= 1'b0;
      bus.Branch_out         <= 1'b0;
    end else if (load_single || load_mul) begin
      bus.out_valid          <= 1'b1;
      bus.result_out         <= load_result;
      bus.zero_signal_out    <= (load_result == '0);
      bus.registro_2_out     <= load_op.store_data;
      bus.branch_target_out  <= load_op.branch_target;
      bus.jump_dest_addr_out <= load_op.jump_dest;
      bus.reg_dest_out       <= load_op.reg_dest;
      bus.MemToReg_out       <= load_op.mem_to_reg;
      bus.RegWrite_out       <= load_op.reg_write;
      bus.MemRead_out        <= load_op.mem_read;
      bus.MemWrite_out       <= load_op.mem_write;
      bus.Branch_out         <= load_op.branch;
    end else if (load_bubble) begin
      // Bubbles keep the data fields; only valid and control are cleared.
      bus.out_valid    <= 1'b0;
      bus.MemToReg_out <= 1'b0;
      bus.RegWrite_out <= 1'b0;
      bus.MemRead_out  <= 1'b0;
      bus.MemWrite_out <= 1'b0;
      bus.Branch_out   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_execute_pipe.sv
// Directed bench for execute_pipe: ALU ops, branch target, multiplier latency,
// stall/flush behaviour and asynchronous reset, all against hand-computed values.
module tb_execute_pipe;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_compared   = 0;
  int   n_mismatched = 0;
  int   busy_cycles;

  execute_pipe_if #(.DATA_W(32), .REG_W(5), .ADDR_W(11)) bus ();

  execute_pipe #(.DATA_W(32), .REG_W(5), .ADDR_W(11), .MUL_EN(1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(input logic [3:0] ctrl, input logic alu_src,
                        input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] se);
    bus.in_valid    = 1'b1;
    bus.ALUCtrl     = ctrl;
    bus.ALUSrc      = alu_src;
    bus.registro_1  = r1;
    bus.registro_2  = r2;
    bus.sign_extend = se;
  endtask

  initial begin
    bus.in_valid        = 1'b0;
    bus.mem_stall       = 1'b0;
    bus.flush           = 1'b0;
    bus.ALUSrc          = 1'b0;
    bus.RegDst          = 1'b0;
    bus.ALUCtrl         = 4'd0;
    bus.registro_1      = '0;
    bus.registro_2      = '0;
    bus.sign_extend     = '0;
    bus.pc_plus1        = '0;
    bus.jump_dest_addr  = '0;
    bus.reg_dest_r_type = '0;
    bus.reg_dest_l_type = '0;
    bus.MemToReg_in     = 1'b0;
    bus.RegWrite_in     = 1'b0;
    bus.MemRead_in      = 1'b0;
    bus.MemWrite_in     = 1'b0;
    bus.Branch_in       = 1'b0;

    #2;
    check("rst_valid",  bus.out_valid, 0);
    check("rst_result", bus.result_out, 0);
    check("rst_ready",  bus.ex_ready, 0);
    check("rst_regwr",  bus.RegWrite_out, 0);
    repeat (2) @(posedge clock);
    #3 reset = 1'b0;

    // ADD with immediate: 5 + (-1) = 4
    set_op(4'd2, 1'b1, 32'd5, 32'h0, 32'hFFFF_FFFF);
    bus.pc_plus1        = 11'd20;
    bus.jump_dest_addr  = 11'h155;
    bus.RegDst          = 1'b1;
    bus.reg_dest_r_type = 5'd3;
    bus.reg_dest_l_type = 5'd7;
    bus.RegWrite_in     = 1'b1;
    #1 check("add_ready", bus.ex_ready, 1);
    tick();
    check("add_result", bus.result_out, 32'd4);
    check("add_zero",   bus.zero_signal_out, 0);
    check("add_valid",  bus.out_valid, 1);
    check("add_regwr",  bus.RegWrite_out, 1);
    check("add_dest",   bus.reg_dest_out, 5'd3);
    check("add_btgt",   bus.branch_target_out, 11'd19);
    check("add_jump",   bus.jump_dest_addr_out, 11'h155);

    // SUB for beq, branch target 10 + (-3) = 7
    set_op(4'd6, 1'b0, 32'h1234, 32'h1234, 32'hFFFF_FFFD);
    bus.pc_plus1    = 11'd10;
    bus.RegDst      = 1'b0;
    bus.RegWrite_in = 1'b0;
    bus.Branch_in   = 1'b1;
    tick();
    check("sub_zero",   bus.zero_signal_out, 1);
    check("sub_btgt",   bus.branch_target_out, 11'd7);
    check("sub_branch", bus.Branch_out, 1);
    check("sub_dest",   bus.reg_dest_out, 5'd7);
    check("sub_store",  bus.registro_2_out, 32'h1234);
    bus.Branch_in = 1'b0;

    set_op(4'd0, 1'b0, 32'hF0F0_1234, 32'h0FF0_4321, 32'h0);
    tick(); check("and_result", bus.result_out, 32'h00F0_0220);
    set_op(4'd1, 1'b0, 32'hF0F0_1234, 32'h0FF0_4321, 32'h0);
    tick(); check("or_result", bus.result_out, 32'hFFF0_5335);
    set_op(4'd12, 1'b0, 32'hF0F0_1234, 32'h0FF0_4321, 32'h0);
    tick(); check("nor_result", bus.result_out, 32'h000F_ACCA);
    set_op(4'd7, 1'b0, 32'hF0F0_1234, 32'h0FF0_4321, 32'h0);
    tick(); check("slt_result", bus.result_out, 32'd1);
    set_op(4'd3, 1'b0, 32'hF0F0_1234, 32'h0FF0_4321, 32'h0);
    tick();
    check("undef_result", bus.result_out, 32'd0);
    check("undef_zero",   bus.zero_signal_out, 1);

    // Bubble: in_valid low clears valid and control
    bus.RegWrite_in = 1'b1;
    bus.in_valid    = 1'b0;
    tick();
    check("bubble_valid", bus.out_valid, 0);
    check("bubble_regwr", bus.RegWrite_out, 0);

    // MUL 7 * 6; operand change while busy must be ignored
    set_op(4'd8, 1'b0, 32'd7, 32'd6, 32'h0);
    bus.RegWrite_in = 1'b1;
    tick();
    check("mul_accept_bubble", bus.out_valid, 0);
    busy_cycles = 0;
    for (int i = 0; i < 32; i++) begin
      if (bus.ex_ready == 1'b0) busy_cycles++;
      if (i == 0) bus.registro_1 = 32'hDEAD_BEEF;
      tick();
    end
    check("mul_busy_cycles", busy_cycles, 32);
    check("mul_done_ready", bus.ex_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    check("mul_valid",  bus.out_valid, 1);
    check("mul_result", bus.result_out, 32'd42);
    check("mul_regwr",  bus.RegWrite_out, 1);

    // MUL overflow to zero, held 3 cycles in MUL_DONE by mem_stall
    set_op(4'd8, 1'b0, 32'h1_0000, 32'h1_0000, 32'h0);
    tick();
    bus.in_valid = 1'b0;
    repeat (32) tick();
    bus.in_valid  = 1'b1;
    bus.mem_stall = 1'b1;
    #1 check("stall_ready", bus.ex_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold_valid",  bus.out_valid, 0);
      check("stall_hold_result", bus.result_out, 32'd42);
    end
    bus.mem_stall = 1'b0;
    #1 check("unstall_ready", bus.ex_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    check("mulov_valid",  bus.out_valid, 1);
    check("mulov_result", bus.result_out, 32'd0);
    check("mulov_zero",   bus.zero_signal_out, 1);

    // Flush at MUL iteration 10, then a normal ADD
    set_op(4'd8, 1'b0, 32'd3, 32'd5, 32'h0);
    tick();
    repeat (10) tick();
    bus.flush = 1'b1;
    #1 check("flush_ready", bus.ex_ready, 1);
    tick();
    bus.flush = 1'b0;
    check("flush_valid", bus.out_valid, 0);
    check("flush_regwr", bus.RegWrite_out, 0);
    set_op(4'd2, 1'b1, 32'd100, 32'd0, 32'd23);
    #1 check("post_flush_ready", bus.ex_ready, 1);
    tick();
    check("post_flush_result", bus.result_out, 32'd123);
    check("post_flush_valid",  bus.out_valid, 1);

    // Stall on a single-cycle op holds EX/MEM, then flush kills a valid op
    set_op(4'd2, 1'b1, 32'd1, 32'd0, 32'd1);
    bus.mem_stall = 1'b1;
    #1 check("stall1_ready", bus.ex_ready, 0);
    tick();
    check("stall1_result", bus.result_out, 32'd123);
    check("stall1_valid",  bus.out_valid, 1);
    bus.mem_stall = 1'b0;
    bus.flush     = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush1_valid", bus.out_valid, 0);
    check("flush1_regwr", bus.RegWrite_out, 0);

    // Asynchronous reset mid-MUL, then SLT -1 < 1
    set_op(4'd8, 1'b0, 32'd2, 32'd3, 32'h0);
    tick();
    repeat (3) tick();
    #3 reset = 1'b1;
    #1;
    check("amid_valid",  bus.out_valid, 0);
    check("amid_result", bus.result_out, 0);
    check("amid_dest",   bus.reg_dest_out, 0);
    check("amid_ready",  bus.ex_ready, 0);
    #2 reset = 1'b0;
    set_op(4'd7, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0);
    #1 check("post_rst_ready", bus.ex_ready, 1);
    tick();
    check("post_rst_slt",   bus.result_out, 32'd1);
    check("post_rst_valid", bus.out_valid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule

// File: doc/execute_pipe.md
Name: execute_pipe

Overview:
- Parametrised EX stage with an integrated EX/MEM pipeline register. Sits between the ID/EX register and the memory stage.
- Adds capabilities the single-cycle execute block lacks:
  - 4-bit ALU control with an extended op set.
  - Iterative multi-cycle multiplier with a stall handshake.
  - Valid/stall/flush pipeline control.
  - Branch-target computation in EX.

Parameters:
- DATA_W, 32, operand/result width.
- REG_W, 5, register-address width.
- ADDR_W, 11, instruction-address width (pc_plus1, jump/branch targets).
- MUL_EN, 1, 1 = MUL op implemented; 0 = MUL decodes as ADD, single cycle.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  ID/EX holds a real instruction.
- ex_ready  out  1  ID/EX may advance this cycle.
- mem_stall  in  1  memory stage cannot accept; EX/MEM holds.
- flush  in  1  kill the instruction currently in EX.
- ALUSrc, RegDst  in  1 each  operand-2 select (1 = sign_extend); dest select (1 = r-type).
- ALUCtrl  in  4  0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT (signed), 8 MUL, 12 NOR; others give result 0.
- registro_1, registro_2, sign_extend  in  DATA_W  operands.
- pc_plus1  in  ADDR_W  address of next instruction.
- jump_dest_addr  in  ADDR_W  jump target, passed through.
- reg_dest_r_type, reg_dest_l_type  in  REG_W  destination candidates.
- MemToReg_in, RegWrite_in, MemRead_in, MemWrite_in, Branch_in  in  1 each  control bits.
- out_valid  out  1  EX/MEM holds a real instruction.
- result_out, registro_2_out  out  DATA_W  ALU result; store data.
- branch_target_out  out  ADDR_W  pc_plus1 + sign_extend[ADDR_W-1:0], wraps modulo 2^ADDR_W.
- jump_dest_addr_out  out  ADDR_W  registered pass-through.
- reg_dest_out  out  REG_W  selected destination.
- zero_signal_out  out  1  result == 0.
- MemToReg_out, RegWrite_out, MemRead_out, MemWrite_out, Branch_out  out  1 each  registered control bits.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, multiplier counter 0. Reset takes effect immediately when asserted, including mid-multiply.
- FSM states:
  - IDLE: accepts single-cycle ops.
  - MUL_BUSY: runs DATA_W shift-add iterations; lower DATA_W bits of the unsigned product are kept, overflow is discarded.
  - MUL_DONE: result ready, waiting to load EX/MEM.
- Single-cycle op (IDLE, in_valid, not MUL, !mem_stall, !flush):
  - EX/MEM loads at the next edge; out_valid = 1.
  - ex_ready = 1 in the same cycle.
  - Latency: 1 cycle.
- MUL accept (IDLE, in_valid, MUL, !flush):
  - Operands, control bits and destination are latched; FSM goes to MUL_BUSY with counter = DATA_W.
  - ex_ready = 0 from acceptance until completion; input changes are ignored while busy.
  - Counter decrements each cycle; at 0, FSM goes to MUL_DONE.
  - In MUL_DONE with !mem_stall: EX/MEM loads, ex_ready = 1, FSM returns to IDLE.
  - Latency from acceptance edge to out_valid: DATA_W+1 cycles.
- EX/MEM loads a bubble (out_valid = 0, all control outputs 0; data outputs don't-care but held) when either:
  - in_valid = 0 in IDLE with !mem_stall, or
  - the FSM is in MUL_BUSY with !mem_stall.
- mem_stall = 1: every EX/MEM output holds its value. ex_ready = 0. A MUL in progress keeps iterating; a finished MUL waits in MUL_DONE.
- flush = 1:
  - The EX instruction is discarded; any MUL is aborted and the FSM returns to IDLE.
  - If !mem_stall, EX/MEM loads a bubble; if mem_stall, EX/MEM holds.
  - ex_ready = !mem_stall.
  - flush has priority over completion in MUL_DONE.
- Control outputs are 0 whenever out_valid = 0, so RegWrite_out and MemWrite_out never fire on bubbles.
- zero_signal_out is computed on the full DATA_W result, including MUL.
- SLT uses signed compare; result is {DATA_W-1 zeros, lt}.
- MUL_EN = 0: ALUCtrl 8 behaves as ADD, FSM never leaves IDLE.

Test Plan:
- ADD path: ALUSrc=1, registro_1=5, sign_extend=0xFFFFFFFF, ALUCtrl=2 -> next edge result_out=4, zero=0, out_valid=1.
- SUB for beq: registro_1=registro_2=0x1234, ALUCtrl=6, pc_plus1=10, sign_extend=-3 (low 11 bits 0x7FD) -> zero=1, branch_target_out=7.
- MUL: operands 7 and 6, in_valid held high -> ex_ready=0 for 32 cycles; result_out=42 and out_valid=1 at edge 33. Also 0x10000*0x10000 -> result 0, zero=1.
- mem_stall asserted during MUL_DONE for 3 cycles -> EX/MEM outputs hold, ex_ready=0; result loads on the first cycle mem_stall drops.
- flush at MUL iteration 10 -> FSM back in IDLE, next edge out_valid=0 with RegWrite_out=0; the next ADD completes normally.
- Reset asserted mid-MUL, between clock edges -> all outputs 0 immediately; after release, SLT of -1 vs 1 gives result 1.
